// File: rtl/uart_pkg.sv
// Shared FSM encodings and oversampling constants for uart_xcvr_fifo.
// The PARITY states exist only when UART_XCVR_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_XCVR_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_XCVR_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word fall-through FIFO; a push while full is dropped and
// a pop while empty is ignored. The output reads 0 whenever the FIFO is empty.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (!do_push && do_pop) level <= level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_xcvr_fifo.sv
// UART transceiver with 16x oversampled receiver and TX/RX FIFOs.
// Define UART_XCVR_PARITY_EN to add one even-parity bit per character.
module uart_xcvr_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DATA_BITS  = 8,
  parameter  int unsigned FIFO_DEPTH = 16,
  localparam int unsigned LW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [15:0]          divisor,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_wr,
  output logic                 tx_full,
  output logic [LW-1:0]        tx_level,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_rd,
  output logic                 rx_empty,
  output logic [LW-1:0]        rx_level,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  logic [15:0] tick_cnt;
  logic        tick;

  assign tick = (tick_cnt == '0) && (divisor != '0);

  always_ff @(posedge sys_clk) begin
    if (sys_rst)              tick_cnt <= '0;
    else if (divisor != '0)   tick_cnt <= (tick_cnt == '0) ? divisor - 16'd1 : tick_cnt - 16'd1;
  end

  // ---------------- transmitter ----------------
  logic                 tx_pop, tx_empty;
  logic [DATA_BITS-1:0] tx_head;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(sys_clk), .rst(sys_rst), .push(tx_wr), .pop(tx_pop), .din(tx_data),
    .dout(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  tx_state_t            tx_state, tx_state_n;
  logic [3:0]           tx_ticks, tx_ticks_n;
  logic [2:0]           tx_idx, tx_idx_n;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
  logic                 tx_line_n, tx_done_n, tx_bit_end;
`ifdef UART_XCVR_PARITY_EN
  logic                 tx_par, tx_par_n;
`endif

  assign tx_busy    = (tx_state != TX_IDLE);
  assign tx_bit_end = tick && (tx_ticks == LAST_TICK);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx_state <= TX_IDLE;
      tx_ticks <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      uart_tx  <= 1'b1;
      tx_done  <= 1'b0;
`ifdef UART_XCVR_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      tx_ticks <= tx_ticks_n;
      tx_idx   <= tx_idx_n;
      tx_sh    <= tx_sh_n;
      uart_tx  <= tx_line_n;
      tx_done  <= tx_done_n;
`ifdef UART_XCVR_PARITY_EN
      tx_par   <= tx_par_n;
`endif
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_ticks_n = tx_ticks;
    tx_idx_n   = tx_idx;
    tx_sh_n    = tx_sh;
    tx_line_n  = uart_tx;
    tx_done_n  = 1'b0;
    tx_pop     = 1'b0;
`ifdef UART_XCVR_PARITY_EN
    tx_par_n   = tx_par;
`endif
    // 4-bit tick counter wraps to 0 exactly at each bit boundary
    if (tx_state != TX_IDLE && tick) tx_ticks_n = tx_ticks + 4'd1;
    unique case (tx_state)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_ticks_n = '0;
          tx_line_n  = 1'b0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_line_n  = tx_sh[0];
          tx_idx_n   = '0;
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          if (tx_idx == LAST_BIT) begin
`ifdef UART_XCVR_PARITY_EN
            tx_line_n  = tx_par;
            tx_state_n = TX_PARITY;
`else
            tx_line_n  = 1'b1;
            tx_state_n = TX_STOP;
`endif
          end else begin
            tx_sh_n   = tx_sh >> 1;
            tx_line_n = tx_sh[1];
            tx_idx_n  = tx_idx + 3'd1;
          end
        end
      end
`ifdef UART_XCVR_PARITY_EN
      TX_PARITY: begin
        if (tx_bit_end) begin
          tx_line_n  = 1'b1;
          tx_state_n = TX_STOP;
        end
      end
`endif
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_done_n = 1'b1;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_line_n  = 1'b0;
            tx_state_n = TX_START;
          end else begin
            tx_state_n = TX_IDLE;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    if (tx_pop) begin
      tx_sh_n = tx_head;
`ifdef UART_XCVR_PARITY_EN
      tx_par_n = ^tx_head;
`endif
    end
  end

  // ---------------- receiver ----------------
  logic [1:0]           rx_sync;
  logic                 rx_s;
  rx_state_t            rx_state, rx_state_n;
  logic [3:0]           rx_ticks, rx_ticks_n;
  logic [2:0]           rx_idx, rx_idx_n;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
  logic                 rx_push, rx_full, rx_bit_end, par_ok;
  logic                 rx_done_n, frame_err_n, overrun_n;

  assign rx_s       = rx_sync[1];
  assign rx_bit_end = tick && (rx_ticks == LAST_TICK);

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(sys_clk), .rst(sys_rst), .push(rx_push), .pop(rx_rd), .din(rx_sh),
    .dout(rx_data), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

`ifdef UART_XCVR_PARITY_EN
  logic rx_par_bad, rx_par_bad_n, parity_err_n;
  assign par_ok = !rx_par_bad;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_par_bad <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_par_bad <= rx_par_bad_n;
      parity_err <= parity_err_n;
    end
  end
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_sync   <= 2'b11;
      rx_state  <= RX_IDLE;
      rx_ticks  <= '0;
      rx_idx    <= '0;
      rx_sh     <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_sync   <= {rx_sync[0], uart_rx};
      rx_state  <= rx_state_n;
      rx_ticks  <= rx_ticks_n;
      rx_idx    <= rx_idx_n;
      rx_sh     <= rx_sh_n;
      rx_done   <= rx_done_n;
      frame_err <= frame_err_n;
      overrun   <= overrun_n;
    end
  end

  always_comb begin
    rx_state_n  = rx_state;
    rx_ticks_n  = rx_ticks;
    rx_idx_n    = rx_idx;
    rx_sh_n     = rx_sh;
    rx_push     = 1'b0;
    rx_done_n   = 1'b0;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;
`ifdef UART_XCVR_PARITY_EN
    rx_par_bad_n = rx_par_bad;
    parity_err_n = 1'b0;
`endif
    if (rx_state != RX_IDLE && rx_state != RX_BREAK && tick) rx_ticks_n = rx_ticks + 4'd1;
    unique case (rx_state)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_ticks_n = '0;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        // re-check at mid start bit; realigns later samples to mid-bit
        if (tick && rx_ticks == MID_TICK) begin
          rx_ticks_n = '0;
          rx_idx_n   = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_sh_n = {rx_s, rx_sh[DATA_BITS-1:1]};
          if (rx_idx == LAST_BIT) begin
`ifdef UART_XCVR_PARITY_EN
            rx_state_n = RX_PARITY;
`else
            rx_state_n = RX_STOP;
`endif
          end else begin
            rx_idx_n = rx_idx + 3'd1;
          end
        end
      end
`ifdef UART_XCVR_PARITY_EN
      RX_PARITY: begin
        if (rx_bit_end) begin
          rx_par_bad_n = rx_s ^ (^rx_sh);
          rx_state_n   = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (rx_bit_end) begin
          rx_state_n = RX_IDLE;
          if (!rx_s) begin
            frame_err_n = 1'b1;
            rx_state_n  = RX_BREAK;
          end else if (!par_ok) begin
`ifdef UART_XCVR_PARITY_EN
            parity_err_n = 1'b1;
`endif
          end else if (rx_full) begin
            overrun_n = 1'b1;
          end else begin
            rx_push   = 1'b1;
            rx_done_n = 1'b1;
          end
        end
      end
      RX_BREAK: begin
        if (rx_s) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_xcvr_fifo.sv
// Directed bench for uart_xcvr_fifo (DATA_BITS=8, FIFO_DEPTH=4, divisor=2).
// Parity checks are compiled when UART_XCVR_PARITY_EN is defined.
module tb_uart_xcvr_fifo;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned BIT_CYC = 32;
`ifdef UART_XCVR_PARITY_EN
  localparam int unsigned FRAME_CYC = 11 * BIT_CYC;
`else
  localparam int unsigned FRAME_CYC = 10 * BIT_CYC;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] divisor = 16'd2;
  logic        drv = 1'b1;
  logic        loop = 1'b0;
  logic        rx_line;
  logic        uart_tx;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_wr = 1'b0;
  logic        tx_full, tx_busy, tx_done;
  logic [2:0]  tx_level, rx_level;
  logic [7:0]  rx_data;
  logic        rx_rd = 1'b0;
  logic        rx_empty, rx_done, frame_err, overrun, parity_err;
`ifdef UART_XCVR_PARITY_EN
  logic        par_flip = 1'b0;
`endif

  assign rx_line = loop ? uart_tx : drv;

  uart_xcvr_fifo #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) dut (
    .sys_clk(clk), .sys_rst(rst), .divisor(divisor), .uart_rx(rx_line), .uart_tx(uart_tx),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full), .tx_level(tx_level),
    .tx_busy(tx_busy), .tx_done(tx_done), .rx_data(rx_data), .rx_rd(rx_rd),
    .rx_empty(rx_empty), .rx_level(rx_level), .rx_done(rx_done), .frame_err(frame_err),
    .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0, n_err = 0;
  int unsigned cyc = 0, n_rxd = 0, n_txd = 0, n_fe = 0, n_ov = 0, n_pe = 0;
  int unsigned last_txd = 0, prev_txd = 0;

  always @(negedge clk) begin
    cyc++;
    if (rx_done)    n_rxd++;
    if (frame_err)  n_fe++;
    if (overrun)    n_ov++;
    if (parity_err) n_pe++;
    if (tx_done) begin
      n_txd++;
      prev_txd = last_txd;
      last_txd = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic write_tx(input logic [7:0] d);
    tx_data = d;
    tx_wr   = 1'b1;
    step(1);
    tx_wr   = 1'b0;
  endtask

  task automatic read_rx(input string tag, input logic [7:0] exp);
    check(tag, 32'(rx_data), 32'(exp));
    rx_rd = 1'b1;
    step(1);
    rx_rd = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drv = 1'b0;
    step(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      drv = d[i];
      step(BIT_CYC);
    end
`ifdef UART_XCVR_PARITY_EN
    drv = (^d) ^ par_flip;
    step(BIT_CYC);
`endif
    drv = stop;
    step(BIT_CYC);
    drv = 1'b1;
    step(BIT_CYC);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned b_rx, b_tx, b_fe, b_ov;
    logic [7:0] bytes5 [5];
    bytes5[0] = 8'h11; bytes5[1] = 8'h22; bytes5[2] = 8'h33;
    bytes5[3] = 8'h44; bytes5[4] = 8'h55;

    // reset state
    rst = 1'b1;
    step(3);
    check("rst_uart_tx",    32'(uart_tx),    32'h1);
    check("rst_tx_busy",    32'(tx_busy),    32'h0);
    check("rst_tx_done",    32'(tx_done),    32'h0);
    check("rst_tx_full",    32'(tx_full),    32'h0);
    check("rst_tx_level",   32'(tx_level),   32'h0);
    check("rst_rx_empty",   32'(rx_empty),   32'h1);
    check("rst_rx_level",   32'(rx_level),   32'h0);
    check("rst_rx_data",    32'(rx_data),    32'h0);
    check("rst_rx_done",    32'(rx_done),    32'h0);
    check("rst_frame_err",  32'(frame_err),  32'h0);
    check("rst_overrun",    32'(overrun),    32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    rst = 1'b0;
    step(2);

    // loopback, three back-to-back frames
    loop = 1'b1;
    b_rx = n_rxd; b_tx = n_txd;
    write_tx(8'hA1);
    check("lb_level_after_wr", 32'(tx_level), 32'h1);
    check("lb_line_still_idle", 32'(uart_tx), 32'h1);
    write_tx(8'h00);
    check("lb_start_bit_low", 32'(uart_tx), 32'h0);
    check("lb_tx_busy", 32'(tx_busy), 32'h1);
    check("lb_level_pop_push", 32'(tx_level), 32'h1);
    write_tx(8'h02);
    check("lb_level_two", 32'(tx_level), 32'h2);
    step(3 * FRAME_CYC + 64);
    check("lb_rx_done_cnt", n_rxd - b_rx, 32'd3);
    check("lb_tx_done_cnt", n_txd - b_tx, 32'd3);
    check("lb_frame_cycles", last_txd - prev_txd, FRAME_CYC);
    check("lb_rx_level", 32'(rx_level), 32'h3);
    check("lb_tx_idle", 32'(tx_busy), 32'h0);
    read_rx("lb_rd0", 8'hA1);
    read_rx("lb_rd1", 8'h00);
    read_rx("lb_rd2", 8'h02);
    check("lb_rx_empty", 32'(rx_empty), 32'h1);
    check("lb_rx_data_empty", 32'(rx_data), 32'h0);
    loop = 1'b0;
    step(BIT_CYC);

    // framing error then good frame
    b_rx = n_rxd; b_fe = n_fe;
    send_frame(8'h55, 1'b0);
    step(BIT_CYC);
    check("fe_pulses", n_fe - b_fe, 32'd1);
    check("fe_rx_empty", 32'(rx_empty), 32'h1);
    check("fe_no_rx_done", n_rxd - b_rx, 32'd0);
    send_frame(8'h3C, 1'b1);
    check("fe_next_rx_done", n_rxd - b_rx, 32'd1);
    check("fe_next_level", 32'(rx_level), 32'h1);
    check("fe_no_extra_err", n_fe - b_fe, 32'd1);
    read_rx("fe_next_data", 8'h3C);

    // overrun on the fifth unread frame
    b_rx = n_rxd; b_ov = n_ov;
    for (int i = 0; i < 5; i++) send_frame(bytes5[i], 1'b1);
    check("ov_rx_level", 32'(rx_level), 32'h4);
    check("ov_pulses", n_ov - b_ov, 32'd1);
    check("ov_rx_done_cnt", n_rxd - b_rx, 32'd4);
    for (int i = 0; i < 4; i++) read_rx("ov_rd", bytes5[i]);
    check("ov_rx_empty", 32'(rx_empty), 32'h1);

    // TX FIFO full: six writes, first popped at once, sixth dropped
    b_tx = n_txd;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) check("txf_level_3", 32'(tx_level), 32'h3);
      if (i == 4) check("txf_not_full", 32'(tx_full), 32'h0);
      if (i == 5) check("txf_full_on_6th", 32'(tx_full), 32'h1);
      write_tx(8'h61 + 8'(i));
    end
    check("txf_level_4", 32'(tx_level), 32'h4);
    step(5 * FRAME_CYC + 64);
    check("txf_tx_done_cnt", n_txd - b_tx, 32'd5);
    check("txf_idle", 32'(tx_busy), 32'h0);
    check("txf_level_0", 32'(tx_level), 32'h0);
    step(FRAME_CYC);
    check("txf_no_6th_frame", n_txd - b_tx, 32'd5);

    // glitch of 5 ticks on the RX line
    b_rx = n_rxd; b_fe = n_fe;
    drv = 1'b0;
    step(10);
    drv = 1'b1;
    step(3 * BIT_CYC);
    check("gl_no_rx_done", n_rxd - b_rx, 32'd0);
    check("gl_no_frame_err", n_fe - b_fe, 32'd0);
    check("gl_rx_empty", 32'(rx_empty), 32'h1);

    // reset in the middle of a TX frame
    write_tx(8'h00);
    write_tx(8'h00);
    step(4 * BIT_CYC);
    check("mr_line_low", 32'(uart_tx), 32'h0);
    check("mr_level_1", 32'(tx_level), 32'h1);
    rst = 1'b1;
    step(1);
    check("mr_line_high", 32'(uart_tx), 32'h1);
    check("mr_level_0", 32'(tx_level), 32'h0);
    check("mr_busy_0", 32'(tx_busy), 32'h0);
    rst = 1'b0;
    step(2);

`ifdef UART_XCVR_PARITY_EN
    begin
      int unsigned k, b_pe;
      loop = 1'b1;
      b_rx = n_rxd;
      write_tx(8'h01);
      k = 0;
      while (uart_tx && k < 8) begin
        step(1);
        k++;
      end
      check("par_start_seen", 32'(uart_tx), 32'h0);
      step(9 * BIT_CYC + 16);
      check("par_bit_on_line", 32'(uart_tx), 32'h1);
      step(2 * BIT_CYC);
      check("par_lb_rx_done", n_rxd - b_rx, 32'd1);
      read_rx("par_lb_data", 8'h01);
      loop = 1'b0;
      step(BIT_CYC);
      b_rx = n_rxd; b_pe = n_pe;
      par_flip = 1'b1;
      send_frame(8'h01, 1'b1);
      par_flip = 1'b0;
      check("par_err_pulse", n_pe - b_pe, 32'd1);
      check("par_no_push", n_rxd - b_rx, 32'd0);
      check("par_rx_empty", 32'(rx_empty), 32'h1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_xcvr_fifo.md
# uart_xcvr_fifo

Parametrised UART transceiver with 16× oversampled receiver, configurable character width and independent TX/RX FIFOs. It is the next generation of `uart_transceiver`, used as the host link in front of `dig_core` and as the bench-side UART model. It adds buffering, line-error detection and optional parity, which the single-byte transceiver lacks.

## Interface
- `DATA_BITS`, 8: character width, legal 5..8.
- `FIFO_DEPTH`, 16: entries per FIFO, power of two, 2..256.
- `LW`, derived as $clog2(FIFO_DEPTH+1): width of the level outputs.
- `sys_clk  in  1`: single clock, rising edge.
- `sys_rst  in  1`: synchronous reset, active-high.
- `divisor  in  16`: sys_clk cycles per oversample tick (clk/(16·baud)). A value of 326 gives 9600 baud at 50 MHz.
- `uart_rx  in  1`: serial input, asynchronous, idle high.
- `uart_tx  out  1`: serial output, idle high.
- `tx_data  in  DATA_BITS`: byte to transmit.
- `tx_wr  in  1`: push `tx_data` into the TX FIFO.
- `tx_full  out  1`: TX FIFO full.
- `tx_level  out  LW`: TX FIFO occupancy.
- `tx_busy  out  1`: transmitter not IDLE.
- `tx_done  out  1`: one-cycle pulse at the end of each stop bit.
- `rx_data  out  DATA_BITS`: head of the RX FIFO (first-word fall-through).
- `rx_rd  in  1`: pop the RX FIFO.
- `rx_empty  out  1`: RX FIFO empty.
- `rx_level  out  LW`: RX FIFO occupancy.
- `rx_done  out  1`: one-cycle pulse when a good character is pushed.
- `frame_err  out  1`: one-cycle pulse when a stop bit samples 0.
- `overrun  out  1`: one-cycle pulse when a character is dropped because the RX FIFO is full.
- `parity_err  out  1`: one-cycle pulse on a parity mismatch. Tied 0 without the parity macro.

## Operation
- **Tick generator**
  - Down-counter reloads `divisor-1` and asserts `tick` for one cycle when it reaches 0.
  - `divisor` is sampled at reload.
  - `divisor==0` holds the counter and produces no ticks.
- **TX FSM**: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - Each bit lasts 16 ticks. LSB goes first.
  - In IDLE with the FIFO non-empty, the FSM pops the head into a shift register and enters START.
  - After STOP it pulses `tx_done`. It returns to IDLE, or goes directly to START if the FIFO is still non-empty (back-to-back frames, no idle gap).
- **RX input path**: `uart_rx` passes through a 2-FF synchronizer.
- **RX FSM**: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - A synchronized 0 in IDLE enters START.
  - At the 8th tick the start bit is re-checked. If the line is 1, the FSM returns to IDLE (glitch rejection).
  - Subsequent bits are sampled every 16 ticks, at mid-bit.
  - When the stop sample is 1 and there is no parity error: push to the RX FIFO and pulse `rx_done`. If the FIFO is full, drop the character and pulse `overrun` instead.
  - When the stop sample is 0: pulse `frame_err` and discard the character.
  - After a frame error the FSM waits for the line to return high before it can detect a new start.
- **FIFOs**
  - A push when full is dropped, even if a pop occurs in the same cycle.
  - A pop when empty is ignored.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves the level unchanged.
  - Pointers are `log2(FIFO_DEPTH)` bits wide and wrap modulo the depth.
- When `DATA_BITS<8`, `tx_data` upper bits do not exist. The RX shift register is assembled LSB-first into `DATA_BITS`.

## Timing
- **Reset values**: `uart_tx`=1; all flags and pulses 0; `rx_empty`=1; `tx_full`=0; levels 0; `rx_data`=0; both FSMs IDLE; tick counter 0.
- A reset mid-frame aborts immediately, so `uart_tx` is high on the next cycle and both FIFOs are emptied.
- `tx_full`, `tx_level`, `rx_empty`, `rx_level` and `rx_data` update on the cycle after the push or pop edge.
- **TX latency**: a `tx_wr` into an empty FIFO in IDLE has `uart_tx` low within 2 cycles.
- **Frame length**: (1+DATA_BITS+P+1)·16·divisor cycles, where P is 1 with parity and 0 without.
- **RX latency**: `rx_done` and `rx_empty`=0 occur 1 cycle after the stop-bit mid-sample tick.
- **Ordering**: a stop-bit error has priority over a parity error. Only one error pulse is issued per frame.

## Configuration
- `UART_XCVR_PARITY_EN` defined:
  - One even-parity bit is inserted after the data bits on TX.
  - RX checks that bit; a mismatch discards the character and pulses `parity_err`.
- Macro undefined:
  - No PARITY state is compiled.
  - `parity_err` is driven 0.
  - The frame is 8N1 (or the equivalent for other `DATA_BITS`).

## Structure
- Package `uart_pkg`:
  - `tx_state_t` and `rx_state_t` enums.
  - `OVERSAMPLE=16` and `MID_SAMPLE=8` constants.
- Sub-module `uart_sync_fifo`:
  - Parameters `WIDTH` and `DEPTH`.
  - Signals push/pop/full/empty/level, first-word fall-through output.
  - Instantiated twice, once for TX and once for RX.

## Test plan
- **Loopback** (`uart_tx`→`uart_rx`, `divisor`=2): write 0xA1, 0x00, 0x02 → `rx_done` ×3, reads return 0xA1, 0x00, 0x02 in order. Each frame is 320 cycles, with no idle gap between frames.
- **Framing error**: inject a frame with data 0x55 and stop bit 0 → `frame_err` pulses once, `rx_empty` stays 1; the next good frame 0x3C is received.
- **Overrun** (`FIFO_DEPTH`=4): 5 frames with no reads → `rx_level`=4, one `overrun` pulse, reads return the first 4 bytes.
- **TX full** (`FIFO_DEPTH`=4): 6 back-to-back `tx_wr` while IDLE → one byte is popped immediately, 4 are queued, the 6th is dropped (`tx_full`=1 during that write). Exactly 5 `tx_done` pulses.
- **Glitch and reset**: `uart_rx` low for 5 ticks → no frame, no error. Asserting `sys_rst` mid-TX-frame → `uart_tx`=1 next cycle, `tx_level`=0.
- **Parity** (macro defined): send 0x01 → parity bit 1 on the line. Inject 0x01 with parity bit 0 → `parity_err` pulse, no push.
